// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the 1-to-6 result demultiplexer
package demux_pkg;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 6;
    localparam int SEL_W  = 3;

    // Destination channel selects; 6 and 7 are invalid and get dropped
    localparam logic [SEL_W-1:0] CH_ALU_ADD = 3'd0;
    localparam logic [SEL_W-1:0] CH_ALU_1   = 3'd1;
    localparam logic [SEL_W-1:0] CH_ALU_2   = 3'd2;
    localparam logic [SEL_W-1:0] CH_ALU_3   = 3'd3;
    localparam logic [SEL_W-1:0] CH_ALU_4   = 3'd4;
    localparam logic [SEL_W-1:0] CH_ALU_5   = 3'd5;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_t;

    // True when the select addresses a real channel
    function automatic logic sel_is_valid(input logic [SEL_W-1:0] sel);
        return sel <= CH_ALU_5;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output holding register with valid/ready handshake
module demux_slot #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              writable
);
    import demux_pkg::*;

    chan_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next state: a write always wins and refills; otherwise a held word drains on ready
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        writable = (state_q == CH_EMPTY) || out_ready;
        if (wr_en) begin
            state_d = CH_FULL;
            data_d  = wr_data;
        end else if ((state_q == CH_FULL) && out_ready) begin
            state_d = CH_EMPTY;
        end
    end

    // Slot state and held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == CH_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/demux1to6_16bit.sv
// rtl/demux1to6_16bit.sv - registered 1-to-6 demux of a shared result bus with drop counter
module demux1to6_16bit #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [demux_pkg::SEL_W-1:0]  in_sel,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*DATA_W-1:0]     out_data,
    output logic                         drop_pulse,
    output logic [7:0]                   drop_count
);
    import demux_pkg::*;

    localparam int SEL_SPACE = 1 << SEL_W;

    logic [NUM_CH-1:0]    slot_writable;
    logic [NUM_CH-1:0]    slot_wr_en;
    logic [SEL_SPACE-1:0] sel_writable;
    logic                 sel_valid;
    logic                 accept;

    logic       drop_pulse_q, drop_pulse_d;
    logic [7:0] drop_count_q, drop_count_d;

    // in_ready lookup over the full select space: invalid selects are always accepted
    always_comb begin
        sel_writable                = '1;
        sel_writable[NUM_CH-1:0]    = slot_writable;
        sel_valid                   = sel_is_valid(in_sel);
        in_ready                    = sel_writable[in_sel];
        accept                      = in_valid && in_ready;
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_slot
            assign slot_wr_en[k] = accept && sel_valid && (in_sel == SEL_W'(k));

            demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .wr_en     (slot_wr_en[k]),
                .wr_data   (in_data),
                .out_ready (out_ready[k]),
                .out_valid (out_valid[k]),
                .out_data  (out_data[k*DATA_W +: DATA_W]),
                .writable  (slot_writable[k])
            );
        end
    endgenerate

    // Drop tracking: pulse follows each discarded word, count saturates at 255
    always_comb begin
        drop_pulse_d = accept && !sel_valid;
        drop_count_d = drop_count_q;
        if (drop_pulse_d && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Drop pulse and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux1to6_16bit.sv
// tb/tb_demux1to6_16bit.sv - self-checking bench for the 1-to-6 result demultiplexer
module tb_demux1to6_16bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic [5:0]  out_valid;
    logic [5:0]  out_ready;
    logic [95:0] out_data;
    logic        drop_pulse;
    logic [7:0]  drop_count;

    int tests;
    int failed;

    // Reference model: what each consumer currently holds, and the drop tally
    bit          m_full [6];
    logic [15:0] m_data [6];
    int          m_drops;
    bit          m_pulse;

    demux1to6_16bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input int sel, input logic [5:0] rdy);
        if (sel > 5) return 1'b1;
        return !m_full[sel] || rdy[sel];
    endfunction

    function automatic logic [5:0] model_valid();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = m_full[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = 16'h0000;
        end
        m_drops = 0;
        m_pulse = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 96'(out_valid), 96'(model_valid()));
        check({tag, ".drop_pulse"}, 96'(drop_pulse), 96'(m_pulse));
        check({tag, ".drop_count"}, 96'(drop_count), 96'(m_drops));
        for (int i = 0; i < 6; i++) begin
            if (m_full[i]) check($sformatf("%s.data%0d", tag, i), 96'(out_data[16*i +: 16]), 96'(m_data[i]));
        end
    endtask

    // One clock: drive inputs, check in_ready, clock, advance model, check outputs
    task automatic cycle(input string tag, input logic v, input logic [2:0] s,
                         input logic [15:0] d, input logic [5:0] r, output bit acc);
        bit rdy;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        rdy = model_ready(int'(s), r);
        check({tag, ".in_ready"}, 96'(in_ready), 96'(rdy));
        acc = v && rdy;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            if (acc && int'(s) == i) begin
                m_full[i] = 1'b1;
                m_data[i] = d;
            end else if (m_full[i] && r[i]) begin
                m_full[i] = 1'b0;
            end
        end
        m_pulse = acc && (s > 3'd5);
        if (m_pulse && m_drops < 255) m_drops++;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        bit          acc;
        bit          hold;
        logic        rv;
        logic [2:0]  rs;
        logic [15:0] rd;
        logic [5:0]  rr;

        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = 16'h0;
        out_ready = 6'h0;
        model_reset();

        // Reset state: everything clear, in_ready high for every select
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 96'(out_valid), 96'd0);
        check("rst.out_data", out_data, 96'd0);
        check("rst.drop_pulse", 96'(drop_pulse), 96'd0);
        check("rst.drop_count", 96'(drop_count), 96'd0);
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            check($sformatf("rst.in_ready_sel%0d", s), 96'(in_ready), 96'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word to channel 2, then back-pressure on a second word
        cycle("tp1", 1'b1, 3'd2, 16'hA5A5, 6'b000000, acc);
        check("tp1.valid_const", 96'(out_valid), 96'(6'b000100));
        check("tp1.data2_const", 96'(out_data[47:32]), 96'(16'hA5A5));
        cycle("tp1b", 1'b1, 3'd2, 16'hBEEF, 6'b000000, acc);
        check("tp1b.stall_const", 96'(acc), 96'd0);
        check("tp1b.data2_held", 96'(out_data[47:32]), 96'(16'hA5A5));

        // Drain and refill of channel 3 in the same cycle
        cycle("tp2a", 1'b1, 3'd3, 16'h1111, 6'b000000, acc);
        cycle("tp2b", 1'b1, 3'd3, 16'h2222, 6'b001000, acc);
        check("tp2.accept_const", 96'(acc), 96'd1);
        check("tp2.valid3_const", 96'(out_valid[3]), 96'd1);
        check("tp2.data3_const", 96'(out_data[63:48]), 96'(16'h2222));

        // Empty all channels, then fill all six back to back
        cycle("clr", 1'b0, 3'd0, 16'h0, 6'b111111, acc);
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("fill%0d", i), 1'b1, 3'(i), 16'(i), 6'b000000, acc);
            check($sformatf("fill%0d.accept", i), 96'(acc), 96'd1);
        end
        check("fill.valid_const", 96'(out_valid), 96'(6'b111111));

        // Invalid selects: two drops, pulse on two consecutive cycles, channels untouched
        cycle("drop6", 1'b1, 3'd6, 16'hDEAD, 6'b000000, acc);
        check("drop6.pulse_const", 96'(drop_pulse), 96'd1);
        cycle("drop7", 1'b1, 3'd7, 16'hBEEF, 6'b000000, acc);
        check("drop7.pulse_const", 96'(drop_pulse), 96'd1);
        check("drop7.count_const", 96'(drop_count), 96'd2);
        check("drop7.valid_const", 96'(out_valid), 96'(6'b111111));
        cycle("drop_idle", 1'b0, 3'd0, 16'h0, 6'b000000, acc);
        check("drop_idle.pulse_const", 96'(drop_pulse), 96'd0);

        // Randomized traffic; a stalled word is held stable until accepted
        hold = 1'b0;
        rv = 1'b0; rs = 3'd0; rd = 16'h0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                rv = ($urandom_range(0, 3) != 0);
                rs = 3'($urandom_range(0, 7));
                rd = 16'($urandom);
            end
            rr = 6'($urandom);
            cycle($sformatf("rnd%0d", n), rv, rs, rd, rr, acc);
            hold = rv && !acc;
        end

        // Saturation of the drop counter
        for (int n = 0; n < 300; n++) begin
            cycle("sat", 1'b1, 3'(6 + (n % 2)), 16'(n), 6'b111111, acc);
        end
        check("sat.count_const", 96'(drop_count), 96'd255);

        // Asynchronous reset mid-transfer with channels 1 and 4 full and a write stalled
        cycle("ar1", 1'b1, 3'd1, 16'h1234, 6'b000000, acc);
        cycle("ar4", 1'b1, 3'd4, 16'h4321, 6'b000000, acc);
        check("ar.valid_pre", 96'(out_valid & 6'b010010), 96'(6'b010010));
        in_valid = 1'b1;
        in_sel   = 3'd1;
        in_data  = 16'h5555;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.out_valid", 96'(out_valid), 96'd0);
        check("ar.drop_count", 96'(drop_count), 96'd0);
        check("ar.out_data", out_data, 96'd0);
        check("ar.drop_pulse", 96'(drop_pulse), 96'd0);
        check("ar.in_ready", 96'(in_ready), 96'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cycle("post_rst", 1'b1, 3'd5, 16'hCAFE, 6'b000000, acc);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
